// File: rtl/gpu_mem_pkg.sv
// Shared definitions for the data-memory responder and the LSUs that talk to it.
package gpu_mem_pkg;

  // Default word geometry, shared with the LSU side of the interface.
  localparam int DEFAULT_ADDR_BITS = 8;
  localparam int DEFAULT_DATA_BITS = 8;

  // Responder state encoding.
  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    ACCESS  = 2'b01,
    RESPOND = 2'b10
  } resp_state_t;

  // Width of an index able to address n items (at least one bit).
  function automatic int idx_bits(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/data_mem_responder_if.sv
// Per-thread load/store request bus: packed channels, one lane per LSU.
interface data_mem_responder_if
  import gpu_mem_pkg::*;
#(
  parameter int NUM_CONSUMERS = 4,
  parameter int ADDR_BITS     = DEFAULT_ADDR_BITS,
  parameter int DATA_BITS     = DEFAULT_DATA_BITS
);
  logic [NUM_CONSUMERS-1:0]           mem_read_valid;
  logic [NUM_CONSUMERS*ADDR_BITS-1:0] mem_read_address;
  logic [NUM_CONSUMERS-1:0]           mem_read_ready;
  logic [NUM_CONSUMERS*DATA_BITS-1:0] mem_read_data;
  logic [NUM_CONSUMERS-1:0]           mem_write_valid;
  logic [NUM_CONSUMERS*ADDR_BITS-1:0] mem_write_address;
  logic [NUM_CONSUMERS*DATA_BITS-1:0] mem_write_data;
  logic [NUM_CONSUMERS-1:0]           mem_write_ready;

  // Requester (LSU) side.
  modport master (
    output mem_read_valid, mem_read_address,
    output mem_write_valid, mem_write_address, mem_write_data,
    input  mem_read_ready, mem_read_data, mem_write_ready
  );

  // Memory side.
  modport slave (
    input  mem_read_valid, mem_read_address,
    input  mem_write_valid, mem_write_address, mem_write_data,
    output mem_read_ready, mem_read_data, mem_write_ready
  );
endinterface

// File: rtl/data_mem_responder_rr_arbiter.sv
// Combinational round-robin arbiter: first requester at or after ptr wins.
module rr_arbiter
  import gpu_mem_pkg::*;
#(
  parameter int N = 4,
  localparam int PW = idx_bits(N)
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [PW-1:0] grant_idx,
  output logic          any_grant
);
  logic [PW-1:0] scan_idx;

  // Walk the channels circularly from ptr and lock onto the first request.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    any_grant = 1'b0;
    scan_idx  = '0;
    for (int i = 0; i < N; i++) begin
      scan_idx = PW'((int'(ptr) + i) % N);
      if (!any_grant && req[scan_idx]) begin
        any_grant       = 1'b1;
        grant_idx       = scan_idx;
        grant[scan_idx] = 1'b1;
      end
    end
  end
endmodule

// File: rtl/data_mem_responder.sv
// Data-memory responder: round-robin over request channels, one transaction
// at a time against a single-port array with a fixed access latency.
module data_mem_responder
  import gpu_mem_pkg::*;
#(
  parameter int NUM_CONSUMERS = 4,
  parameter int ADDR_BITS     = DEFAULT_ADDR_BITS,
  parameter int DATA_BITS     = DEFAULT_DATA_BITS,
  parameter int LATENCY       = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  data_mem_responder_if.slave  bus,
  input  logic                 init_we,
  input  logic [ADDR_BITS-1:0] init_addr,
  input  logic [DATA_BITS-1:0] init_data,
  output logic                 busy
);
  localparam int PTR_BITS = idx_bits(NUM_CONSUMERS);
  localparam int CNT_BITS = idx_bits(LATENCY);
  localparam int DEPTH    = 1 << ADDR_BITS;

  logic [DATA_BITS-1:0] mem [0:DEPTH-1];
  logic [DATA_BITS-1:0] rdata_reg [NUM_CONSUMERS];

  resp_state_t              state_reg, state_next;
  logic [CNT_BITS-1:0]      cnt_reg, cnt_next;
  logic [PTR_BITS-1:0]      ch_reg, ch_next;
  logic                     is_write_reg, is_write_next;
  logic [ADDR_BITS-1:0]     addr_reg, addr_next;
  logic [DATA_BITS-1:0]     wdata_reg, wdata_next;
  logic [PTR_BITS-1:0]      rr_ptr_reg, rr_ptr_next;
  logic [NUM_CONSUMERS-1:0] read_ready_reg, read_ready_next;
  logic [NUM_CONSUMERS-1:0] write_ready_reg, write_ready_next;
  logic                     commit;

  logic [NUM_CONSUMERS-1:0] grant;
  logic [PTR_BITS-1:0]      grant_idx;
  logic                     any_grant;

  rr_arbiter #(.N(NUM_CONSUMERS)) u_arb (
    .req       (bus.mem_read_valid | bus.mem_write_valid),
    .ptr       (rr_ptr_reg),
    .grant     (grant),
    .grant_idx (grant_idx),
    .any_grant (any_grant)
  );

  // Next-state logic: grant and latch in IDLE, count down in ACCESS, one ready cycle in RESPOND.
  always_comb begin
    state_next       = state_reg;
    cnt_next         = cnt_reg;
    ch_next          = ch_reg;
    is_write_next    = is_write_reg;
    addr_next        = addr_reg;
    wdata_next       = wdata_reg;
    rr_ptr_next      = rr_ptr_reg;
    read_ready_next  = '0;
    write_ready_next = '0;
    commit           = 1'b0;
    case (state_reg)
      IDLE: begin
        if (any_grant) begin
          // A pending write on the winning channel is served before its read.
          is_write_next = |(grant & bus.mem_write_valid);
          ch_next       = grant_idx;
          addr_next     = is_write_next ? bus.mem_write_address[grant_idx*ADDR_BITS +: ADDR_BITS]
                                        : bus.mem_read_address[grant_idx*ADDR_BITS +: ADDR_BITS];
          wdata_next    = bus.mem_write_data[grant_idx*DATA_BITS +: DATA_BITS];
          cnt_next      = CNT_BITS'(LATENCY - 1);
          rr_ptr_next   = PTR_BITS'((int'(grant_idx) + 1) % NUM_CONSUMERS);
          state_next    = ACCESS;
        end
      end
      ACCESS: begin
        if (cnt_reg == '0) begin
          commit = 1'b1;
          if (is_write_reg) write_ready_next[ch_reg] = 1'b1;
          else              read_ready_next[ch_reg]  = 1'b1;
          state_next = RESPOND;
        end else begin
          cnt_next = CNT_BITS'(int'(cnt_reg) - 1);
        end
      end
      RESPOND: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // State and transaction registers; reset abandons any in-flight operation.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg       <= IDLE;
      cnt_reg         <= '0;
      ch_reg          <= '0;
      is_write_reg    <= 1'b0;
      addr_reg        <= '0;
      wdata_reg       <= '0;
      rr_ptr_reg      <= '0;
      read_ready_reg  <= '0;
      write_ready_reg <= '0;
    end else begin
      state_reg       <= state_next;
      cnt_reg         <= cnt_next;
      ch_reg          <= ch_next;
      is_write_reg    <= is_write_next;
      addr_reg        <= addr_next;
      wdata_reg       <= wdata_next;
      rr_ptr_reg      <= rr_ptr_next;
      read_ready_reg  <= read_ready_next;
      write_ready_reg <= write_ready_next;
    end
  end

  // Array writes: backdoor first so a same-address transaction write lands last and wins.
  always_ff @(posedge clk) begin
    if (init_we) mem[init_addr] <= init_data;
    if (commit && is_write_reg && !reset) mem[addr_reg] <= wdata_reg;
  end

  // Read lanes: only the granted channel's lane is updated, and it holds afterwards.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_CONSUMERS; i++) rdata_reg[i] <= '0;
    end else if (commit && !is_write_reg) begin
      rdata_reg[ch_reg] <= mem[addr_reg];
    end
  end

  for (genvar gi = 0; gi < NUM_CONSUMERS; gi++) begin : g_lane
    assign bus.mem_read_data[gi*DATA_BITS +: DATA_BITS] = rdata_reg[gi];
  end

  assign bus.mem_read_ready  = read_ready_reg;
  assign bus.mem_write_ready = write_ready_reg;
  assign busy                = (state_reg != IDLE);

endmodule

// File: tb/tb_data_mem_responder.sv
// Self-checking bench for data_mem_responder: directed scenarios plus
// randomized multi-channel rounds checked against an arbitration/array model.
module tb_data_mem_responder;
  localparam int N = 4;
  localparam int A = 8;
  localparam int D = 8;
  localparam int L = 2;

  logic         clk = 1'b0;
  logic         reset;
  logic         init_we;
  logic [A-1:0] init_addr;
  logic [D-1:0] init_data;
  logic         busy;

  int checks   = 0;
  int failures = 0;

  logic [D-1:0] model_mem [256];
  logic [D-1:0] lanes [N];

  data_mem_responder_if #(.NUM_CONSUMERS(N), .ADDR_BITS(A), .DATA_BITS(D)) bus ();

  data_mem_responder #(.NUM_CONSUMERS(N), .ADDR_BITS(A), .DATA_BITS(D), .LATENCY(L)) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus),
    .init_we   (init_we),
    .init_addr (init_addr),
    .init_data (init_data),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic preload(input logic [7:0] a, input logic [7:0] d);
    init_we = 1'b1; init_addr = a; init_data = d;
    @(posedge clk); #1;
    init_we = 1'b0;
    model_mem[a] = d;
  endtask

  // Wait (bounded) for the next ready pulse; report channel, op and edges waited.
  task automatic wait_pulse(output int ch, output bit wr, output int gap, input bit chk_busy);
    gap = 0; ch = -1; wr = 1'b0;
    while (ch < 0 && gap < 32) begin
      @(posedge clk); #1;
      gap++;
      if (chk_busy) check("busy_window", busy, 1'b1);
      if (|{bus.mem_read_ready, bus.mem_write_ready}) begin
        check("one_ready", $countones({bus.mem_read_ready, bus.mem_write_ready}), 1);
        for (int i = 0; i < N; i++) begin
          if (bus.mem_read_ready[i])  begin ch = i; wr = 1'b0; end
          if (bus.mem_write_ready[i]) begin ch = i; wr = 1'b1; end
        end
      end
    end
    check("pulse_seen", (ch >= 0), 1'b1);
  endtask

  // Single transaction on one channel with latency, busy and data checks.
  task automatic txn(input int ch, input bit wr, input logic [7:0] addr,
                     input logic [7:0] wd, output logic [7:0] rd);
    int pch, gap;
    bit pwr;
    @(posedge clk); #1;
    if (wr) begin
      bus.mem_write_valid[ch] = 1'b1;
      bus.mem_write_address[ch*A +: A] = addr;
      bus.mem_write_data[ch*D +: D] = wd;
    end else begin
      bus.mem_read_valid[ch] = 1'b1;
      bus.mem_read_address[ch*A +: A] = addr;
    end
    wait_pulse(pch, pwr, gap, 1'b1);
    check("txn_ch", pch, ch);
    check("txn_op", pwr, wr);
    check("txn_latency", gap, L + 1);
    rd = bus.mem_read_data[ch*D +: D];
    if (wr) model_mem[addr] = wd;
    else    check("txn_rdata", rd, model_mem[addr]);
    bus.mem_write_valid[ch] = 1'b0;
    bus.mem_read_valid[ch]  = 1'b0;
    @(posedge clk); #1;
    check("txn_ready_clear", {bus.mem_read_ready, bus.mem_write_ready}, '0);
    check("txn_busy_clear", busy, 1'b0);
    $display("txn ch=%0d wr=%0b addr=%02h wdata=%02h rdata=%02h", ch, wr, addr, wd, rd);
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    for (int c = 0; c < N; c++) lanes[c] = '0;
  endtask

  initial begin
    logic [7:0] rd;
    int pch, gap, ec, mptr;
    bit pwr, ew, first;
    int exp_order[5] = '{0, 1, 2, 3, 0};
    logic [N-1:0] pend_r, pend_w;
    logic [7:0] raddr [N];
    logic [7:0] waddr [N];
    logic [7:0] wdat  [N];
    logic [N*D-1:0] exp_lanes;

    reset = 1'b1; init_we = 1'b0; init_addr = '0; init_data = '0;
    bus.mem_read_valid = '0; bus.mem_read_address = '0;
    bus.mem_write_valid = '0; bus.mem_write_address = '0; bus.mem_write_data = '0;

    // Fill the whole array through the backdoor while reset is held.
    for (int i = 0; i < 256; i++) begin
      init_we = 1'b1; init_addr = A'(i); init_data = D'($urandom);
      model_mem[i] = init_data;
      @(posedge clk); #1;
    end
    init_we = 1'b0;
    check("reset_busy", busy, 1'b0);
    check("reset_rready", bus.mem_read_ready, '0);
    check("reset_wready", bus.mem_write_ready, '0);
    check("reset_rdata", bus.mem_read_data, '0);
    reset = 1'b0;

    // Basic read with latency and busy window.
    preload(8'h10, 8'hAB);
    txn(0, 1'b0, 8'h10, 8'h00, rd);
    check("t_read_data", rd, 8'hAB);

    // Write then read back on channel 2.
    txn(2, 1'b1, 8'h22, 8'h5C, rd);
    txn(2, 1'b0, 8'h22, 8'h00, rd);
    check("t_wr_rd_data", rd, 8'h5C);

    // Address changes after grant must not affect the transaction.
    preload(8'h11, 8'hCD);
    @(posedge clk); #1;
    bus.mem_read_valid[1] = 1'b1; bus.mem_read_address[1*A +: A] = 8'h10;
    @(posedge clk); #1;
    bus.mem_read_address[1*A +: A] = 8'h11;
    wait_pulse(pch, pwr, gap, 1'b1);
    check("latch_ch", pch, 1);
    check("latch_data", bus.mem_read_data[1*D +: D], 8'hAB);
    bus.mem_read_valid[1] = 1'b0;
    $display("latch ch=1 addr=10->11 rdata=%02h", bus.mem_read_data[1*D +: D]);
    @(posedge clk); #1;

    // Reset during ACCESS of a write: no pulse, no array change.
    preload(8'h30, 8'h01);
    bus.mem_write_valid[3] = 1'b1;
    bus.mem_write_address[3*A +: A] = 8'h30;
    bus.mem_write_data[3*D +: D] = 8'hFF;
    @(posedge clk); #1;
    check("abort_busy_pre", busy, 1'b1);
    reset = 1'b1; bus.mem_write_valid[3] = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    check("abort_busy_post", busy, 1'b0);
    check("abort_ready0", {bus.mem_read_ready, bus.mem_write_ready}, '0);
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      check("abort_ready_quiet", {bus.mem_read_ready, bus.mem_write_ready}, '0);
    end
    txn(3, 1'b0, 8'h30, 8'h00, rd);
    check("abort_array", rd, 8'h01);

    // Same-edge collision: transaction write beats backdoor write.
    @(posedge clk); #1;
    bus.mem_write_valid[0] = 1'b1;
    bus.mem_write_address[0*A +: A] = 8'h40;
    bus.mem_write_data[0*D +: D] = 8'h22;
    @(posedge clk); #1;
    @(posedge clk); #1;
    init_we = 1'b1; init_addr = 8'h40; init_data = 8'h11;
    @(posedge clk); #1;
    init_we = 1'b0;
    check("coll_wready", bus.mem_write_ready, 4'b0001);
    bus.mem_write_valid[0] = 1'b0;
    model_mem[8'h40] = 8'h22;
    @(posedge clk); #1;
    txn(0, 1'b0, 8'h40, 8'h00, rd);
    check("coll_data", rd, 8'h22);

    // All four channels read at once, ch0 re-raised after its service.
    pulse_reset();
    for (int c = 0; c < N; c++) begin
      bus.mem_read_valid[c] = 1'b1;
      bus.mem_read_address[c*A +: A] = 8'(8'h50 + c);
    end
    for (int n = 0; n < 5; n++) begin
      wait_pulse(pch, pwr, gap, 1'b0);
      check("order_ch", pch, exp_order[n]);
      check("order_op", pwr, 1'b0);
      // The re-raise cycle after the first pulse consumes one edge of the next gap.
      check("order_gap", gap, (n == 0 || n == 1) ? L + 1 : L + 2);
      if (pch >= 0) begin
        check("order_data", bus.mem_read_data[pch*D +: D], model_mem[8'h50 + pch]);
        bus.mem_read_valid[pch] = 1'b0;
      end
      $display("order n=%0d ch=%0d gap=%0d", n, pch, gap);
      if (n == 0) begin
        @(posedge clk); #1;
        bus.mem_read_valid[0] = 1'b1;
      end
    end
    bus.mem_read_valid = '0;
    @(posedge clk); #1;

    // Randomized rounds against the arbitration/array model.
    pulse_reset();
    mptr = 0;
    check("rand_lanes_reset", bus.mem_read_data, '0);
    for (int r = 0; r < 8; r++) begin
      for (int c = 0; c < N; c++) begin
        pend_r[c] = 1'($urandom_range(0, 1));
        pend_w[c] = ($urandom_range(0, 2) == 0);
        raddr[c]  = 8'(8'h60 + $urandom_range(0, 7));
        waddr[c]  = 8'(8'h60 + $urandom_range(0, 7));
        wdat[c]   = 8'($urandom);
      end
      if ((pend_r | pend_w) == '0) pend_r[$urandom_range(0, N - 1)] = 1'b1;
      @(posedge clk); #1;
      for (int c = 0; c < N; c++) begin
        bus.mem_read_valid[c]  = pend_r[c];
        bus.mem_write_valid[c] = pend_w[c];
        bus.mem_read_address[c*A +: A]  = raddr[c];
        bus.mem_write_address[c*A +: A] = waddr[c];
        bus.mem_write_data[c*D +: D]    = wdat[c];
      end
      first = 1'b1;
      for (int t = 0; t < 2 * N && (pend_r | pend_w) != '0; t++) begin
        wait_pulse(pch, pwr, gap, 1'b0);
        ec = -1;
        for (int k = 0; k < N; k++)
          if (ec < 0 && (pend_r[(mptr + k) % N] || pend_w[(mptr + k) % N])) ec = (mptr + k) % N;
        ew = pend_w[ec];
        check("rand_ch", pch, ec);
        check("rand_op", pwr, ew);
        check("rand_gap", gap, first ? L + 1 : L + 2);
        if (ew) begin
          model_mem[waddr[ec]] = wdat[ec];
          pend_w[ec] = 1'b0;
          bus.mem_write_valid[ec] = 1'b0;
        end else begin
          lanes[ec] = model_mem[raddr[ec]];
          pend_r[ec] = 1'b0;
          bus.mem_read_valid[ec] = 1'b0;
        end
        for (int c = 0; c < N; c++) exp_lanes[c*D +: D] = lanes[c];
        check("rand_lanes", bus.mem_read_data, exp_lanes);
        $display("rand r=%0d ch=%0d wr=%0b gap=%0d lanes=%08h", r, pch, pwr, gap, bus.mem_read_data);
        mptr = (ec + 1) % N;
        first = 1'b0;
      end
      bus.mem_read_valid = '0;
      bus.mem_write_valid = '0;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
